// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging three writeback requesters onto one registered
// register-file write port; REGFILE_WB_SCOREBOARD_EN adds a pending-write scoreboard.
`timescale 1ns/1ps

module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req_valid,
   input  logic [14:0] req_addr,
   input  logic [95:0] req_data,
   output logic [2:0]  req_ready,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic [15:0] wb_count,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  qry_ra1,
   input  logic [4:0]  qry_ra2,
   output logic        qry_busy1,
   output logic        qry_busy2
);

   // Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i];
   // ready is combinational from valid and the pointer only, one-hot or zero.

   logic [1:0]  ptr_q, ptr_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_wa_q, rf_wa_d;
   logic [31:0] rf_wd_q, rf_wd_d;
   logic [15:0] cnt_q, cnt_d;

   logic        gnt_found;
   logic [1:0]  gnt_idx;
   logic [1:0]  cand;
   logic [4:0]  sel_addr;
   logic [31:0] sel_data;
   logic        xfer;
   logic        xfer_wr;

   function automatic logic [1:0] wrap3(input logic [1:0] p, input logic [1:0] k);
      logic [2:0] s;
      s = {1'b0, p} + {1'b0, k};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   // Scan from the farthest candidate back to the pointer so the nearest valid one wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = 2'd0;
      cand      = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         cand = wrap3(ptr_q, 2'(k));
         if (req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
      if (reset) gnt_found = 1'b0;
   end

   always_comb begin
      sel_addr = req_addr[4:0];
      sel_data = req_data[31:0];
      case (gnt_idx)
         2'd1: begin
            sel_addr = req_addr[9:5];
            sel_data = req_data[63:32];
         end
         2'd2: begin
            sel_addr = req_addr[14:10];
            sel_data = req_data[95:64];
         end
         default: ;
      endcase
   end

   assign req_ready = gnt_found ? (3'b001 << gnt_idx) : 3'b000;
   assign xfer      = gnt_found;
   assign xfer_wr   = xfer && (sel_addr != 5'd0);

   always_comb begin
      ptr_d   = ptr_q;
      rf_we_d = xfer_wr;
      rf_wa_d = rf_wa_q;
      rf_wd_d = rf_wd_q;
      cnt_d   = cnt_q;
      if (xfer) begin
         ptr_d   = wrap3(gnt_idx, 2'd1);
         rf_wa_d = sel_addr;
         rf_wd_d = sel_data;
      end
      if (xfer_wr) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q   <= 2'd0;
         rf_we_q <= 1'b0;
         rf_wa_q <= 5'd0;
         rf_wd_q <= 32'd0;
         cnt_q   <= 16'd0;
      end else begin
         ptr_q   <= ptr_d;
         rf_we_q <= rf_we_d;
         rf_wa_q <= rf_wa_d;
         rf_wd_q <= rf_wd_d;
         cnt_q   <= cnt_d;
      end
   end

   // A pulse registered just before reset rises must not reach the register file.
   assign rf_we    = rf_we_q & ~reset;
   assign rf_wa    = rf_wa_q;
   assign rf_wd    = rf_wd_q;
   assign wb_count = cnt_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
   logic [31:0] busy_q, busy_d;

   // Set is applied after clear so an issue to the register being retired keeps it pending.
   always_comb begin
      busy_d = busy_q;
      if (xfer_wr) busy_d[sel_addr] = 1'b0;
      if (iss_valid && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy_q <= 32'd0;
      else       busy_q <= busy_d;
   end

   assign qry_busy1 = busy_q[qry_ra1];
   assign qry_busy2 = busy_q[qry_ra2];
`else
   logic unused_sb;
   assign unused_sb = ^{iss_valid, iss_rd, qry_ra1, qry_ra2};
   assign qry_busy1 = 1'b0;
   assign qry_busy2 = 1'b0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL use clock clk, and reset reset, synchronous, active-high; clock clk.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- req_valid  in  3  per-requester writeback valid (bit i = requester i)
- req_addr  in  15  destination register, 5 bits per requester, requester i at [5i+4:5i]
- req_data  in  96  write data, 32 bits per requester, requester i at [32i+31:32i]
- req_ready  out  3  per-requester accept, combinational, one-hot or zero
- rf_we  out  1  register-file write enable, registered
- rf_wa  out  5  register-file write address, registered
- rf_wd  out  32  register-file write data, registered
- wb_count  out  16  accepted non-zero-destination writes, wrapping counter
- iss_valid  in  1  issue stage marks a destination pending (scoreboard only)
- iss_rd  in  5  destination being marked pending (scoreboard only)
- qry_ra1, qry_ra2  in  5 each  source registers to check (scoreboard only)
- qry_busy1, qry_busy2  out  1 each  source has a pending write (scoreboard only)

Function
REQ-003 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1; at most one transfer per cycle.
REQ-004 req_ready SHALL grant the first valid requester in round-robin order, starting at (last granted + 1) mod 3; after reset the search starts at requester 0.
REQ-005 The round-robin pointer SHALL advance only on a transfer; with no request it SHALL hold.
REQ-006 req_ready[i] SHALL be 0 whenever req_valid[i] is 0; ready SHALL NOT depend on any rf_* output.
REQ-007 A transfer in cycle N SHALL drive rf_we=1, rf_wa=addr, rf_wd=data during cycle N+1 (latency 1); with no transfer in cycle N, rf_we=0 in N+1 and rf_wa/rf_wd SHALL hold their previous values.
REQ-008 A transfer with addr=0 SHALL complete the handshake but SHALL produce rf_we=0 and SHALL NOT increment wb_count.
REQ-009 wb_count SHALL increment by 1 per non-zero-destination transfer and wrap 0xFFFF -> 0x0000.
REQ-010 A requester holding req_valid SHALL be granted within 3 cycles (no starvation).

Reset
REQ-011 On reset: rf_we=0, rf_wa=0, rf_wd=0, wb_count=0, pointer=requester 0, all scoreboard bits clear.
REQ-012 req_ready SHALL be 0 in every cycle reset is high; in-flight requests SHALL be dropped; an rf_we pulse due in the cycle after reset asserts SHALL be suppressed.

Configuration
REQ-013 Macro REGFILE_WB_SCOREBOARD_EN SHALL compile in a 32-bit pending-write scoreboard; without it the iss_*/qry_* ports SHALL still exist, inputs SHALL be ignored and qry_busy1/2 SHALL be tied 0.
REQ-014 With the macro: iss_valid with iss_rd!=0 SHALL set busy[iss_rd] at the next edge; a transfer with addr!=0 SHALL clear busy[addr] at the next edge; set and clear to the same register in one cycle SHALL leave it set; busy[0] SHALL always read 0.
REQ-015 With the macro: qry_busy1/2 SHALL be combinational reads of the registered busy vector (no same-cycle forwarding of set or clear).

Verification
REQ-016 Reset, then req_valid=3'b111, all addr=5 -> grants 0,1,2,0 on successive cycles; rf_we=1, rf_wa=5 each cycle from cycle 2; wb_count=4 after the fourth write appears.
REQ-017 Only requester 2 valid, addr=7, data=0xDEADBEEF -> req_ready=3'b100 same cycle; next cycle rf_we=1, rf_wa=7, rf_wd=0xDEADBEEF; following cycle rf_we=0, rf_wa=7 held.
REQ-018 Requester 1 transfers with addr=0 -> req_ready[1]=1, next cycle rf_we=0, wb_count unchanged.
REQ-019 wb_count preloaded to 0xFFFF by 65535 writes, one more write to addr=3 -> wb_count=0x0000.
REQ-020 With REGFILE_WB_SCOREBOARD_EN: iss_rd=9, then qry_ra1=9 -> qry_busy1=1; transfer addr=9 coincident with iss_rd=9 -> stays 1; transfer addr=9 alone -> qry_busy1=0 next cycle; iss_rd=0 -> qry_busy for 0 stays 0.
REQ-021 Reset asserted in the cycle after a transfer, req_valid held high -> rf_we=0 throughout reset, req_ready=0, wb_count=0, first grant after reset to requester 0.
